multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port instr, input, 32 bits: the instruction word from instruction memory, valid during the IF state.
REQ-004 The block SHALL have the port PCSel, output, 3 bits: 000 PC+4, 001 branch, 010 jmp, 011 jr, 100 resetPC, 111 hold.
REQ-005 The block SHALL have the port bne, output, 1 bit: qualifies PCSel=001; 1 means branch on not-zero, 0 means branch on zero.
REQ-006 The block SHALL have the ports IRWrite, RegWrite, MemRead, MemWrite and Link, each an output of 1 bit: per-cycle write and read strobes; Link selects $31 and PC+4 as the register writeback.
REQ-007 The block SHALL have the port ALUOp, output, 3 bits: 000 add, 001 sub, 010 R-type decoded by funct.
REQ-008 The block SHALL have the port state, output, 3 bits: the current FSM state, for debug.
REQ-009 The block SHALL have the port halted, output, 1 bit: high while in the HALT state.

Function
REQ-010 The FSM states SHALL be RSTPC, IF, ID, EXE, MEM, WB and HALT.
REQ-011 All outputs SHALL be decoded combinationally from the state and the latched opcode/funct, with no output registers.
REQ-012 Every state and opcode combination not listed in REQ-013 to REQ-019 SHALL drive PCSel=111, all strobes 0 and ALUOp=000.
REQ-013 In RSTPC the block SHALL drive PCSel=100 and SHALL move to IF on the next edge.
REQ-014 In IF the block SHALL drive IRWrite=1 and PCSel=111, SHALL latch instr[31:26] as opcode and instr[5:0] as funct on the exit edge, and SHALL then move to ID.
REQ-015 In ID the block SHALL decode the latched opcode as follows:
- j (000010): drive PCSel=010, then go to IF.
- jal (000011): drive PCSel=010, RegWrite=1 and Link=1, then go to IF.
- R-type with funct 001000 (jr): drive PCSel=011, then go to IF.
- halt (111111): drive PCSel=111, then go to HALT.
- Unknown opcode: treat as a nop, drive PCSel=000, then go to IF.
- All other opcodes: drive PCSel=111, then go to EXE.
REQ-016 In EXE, for beq (000100) or bne (000101), the block SHALL drive PCSel=001, ALUOp=001 and bne=(opcode==000101), then go to IF; the taken/not-taken decision belongs to the PC unit.
REQ-017 In EXE, for lw (100011) or sw (101011), the block SHALL drive ALUOp=000 and PCSel=111, then go to MEM.
REQ-018 In EXE, for R-type (ALUOp=010) or addi (001000, ALUOp=000), the block SHALL drive PCSel=111, then go to WB.
REQ-019 In MEM:
- sw: drive MemWrite=1 and PCSel=000, then go to IF.
- lw: drive MemRead=1 and PCSel=111, then go to WB.
REQ-020 In WB the block SHALL drive RegWrite=1 (and MemRead=1 when the opcode is lw) with PCSel=000, then go to IF.
REQ-021 Every instruction SHALL drive a non-hold PCSel in exactly one cycle, its final cycle, and PCSel=111 in every other cycle.
REQ-022 The block SHALL never assert MemRead and MemWrite in the same cycle.
REQ-023 Instruction latency SHALL be: j/jal/jr/nop 2 cycles; beq/bne 3; R-type/addi/sw 4; lw 5.
REQ-024 HALT SHALL be absorbing: PCSel=111, halted=1, all strobes 0, exited only by Reset.
REQ-025 Undefined state encodings SHALL transition to RSTPC on the next edge.

Reset
REQ-026 Asserting Reset SHALL force the state to RSTPC and clear opcode/funct to 0 immediately, without waiting for a CLK edge.
REQ-027 While Reset is asserted the outputs SHALL be PCSel=100 with all strobes, bne, Link and halted at 0, and ALUOp=000.
REQ-028 Reset asserted mid-instruction, including MEM of sw, SHALL suppress the pending strobes in the same cycle.
REQ-029 After Reset is deasserted, the block SHALL spend one RSTPC cycle and then enter IF.

Structure
REQ-030 A shared package cpu_defs_pkg SHALL hold the state encodings, the opcode and funct constants, the PCSel codes (including HOLD=111) and the ALUOp codes.
REQ-031 The opcode/funct decode SHALL be a single combinational sub-module named main_decoder, with the FSM kept in multi_cycle_control_unit.

Verification
REQ-032 The bench SHALL check reset: pulse Reset mid-cycle -> PCSel=100 immediately, one RSTPC cycle after release, then IF with IRWrite=1.
REQ-033 The bench SHALL check lw: instr=0x8C020004 -> IF, ID, EXE, MEM(MemRead), WB(RegWrite) in 5 cycles, with PCSel=000 only in WB.
REQ-034 The bench SHALL check bne: instr=0x14220003 -> EXE drives PCSel=001, bne=1 and ALUOp=001; the next state is IF.
REQ-035 The bench SHALL check jr: instr=0x03E00008 -> ID drives PCSel=011; 2-cycle latency; no RegWrite.
REQ-036 The bench SHALL check halt: instr=0xFC000000 -> HALT with PCSel=111 held for 100 cycles; Reset then returns the FSM to RSTPC.
REQ-037 The bench SHALL check reset during sw: assert Reset in MEM -> MemWrite drops to 0 the same cycle and PCSel=100.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states,
// instruction field constants, PC select codes and ALU operation codes.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    S_RSTPC = 3'd0,
    S_IF    = 3'd1,
    S_ID    = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] PC_PLUS4  = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b001;
  localparam logic [2:0] PC_JMP    = 3'b010;
  localparam logic [2:0] PC_JR     = 3'b011;
  localparam logic [2:0] PC_RESET  = 3'b100;
  localparam logic [2:0] PC_HOLD   = 3'b111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;

  // Instruction class produced by the decoder; the FSM only ever looks at this.
  typedef enum logic [3:0] {
    I_NOP,
    I_J,
    I_JAL,
    I_JR,
    I_HALT,
    I_BEQ,
    I_BNE,
    I_LW,
    I_SW,
    I_ADDI,
    I_RTYPE
  } instr_class_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode/funct decode into an instruction class.
// Any opcode not recognised here is treated as a nop.
module main_decoder
  import cpu_defs_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class
);

  always_comb begin
    instr_class = I_NOP;
    case (opcode)
      OP_RTYPE: instr_class = (funct == FUNCT_JR) ? I_JR : I_RTYPE;
      OP_J:     instr_class = I_J;
      OP_JAL:   instr_class = I_JAL;
      OP_BEQ:   instr_class = I_BEQ;
      OP_BNE:   instr_class = I_BNE;
      OP_ADDI:  instr_class = I_ADDI;
      OP_LW:    instr_class = I_LW;
      OP_SW:    instr_class = I_SW;
      OP_HALT:  instr_class = I_HALT;
      default:  instr_class = I_NOP;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM. Outputs are purely combinational from the
// current state and the opcode/funct latched when leaving IF.
module multi_cycle_control_unit
  import cpu_defs_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] instr,
  output logic [2:0]  PCSel,
  output logic        bne,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Link,
  output logic [2:0]  ALUOp,
  output logic [2:0]  state,
  output logic        halted
);

  state_t       cur_state;
  state_t       next_state;
  logic [5:0]   opcode;
  logic [5:0]   funct;
  instr_class_t instr_class;

  // Only the opcode and funct fields steer control; the rest belongs to the datapath.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  main_decoder u_main_decoder (
    .opcode      (opcode),
    .funct       (funct),
    .instr_class (instr_class)
  );

  assign state = cur_state;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cur_state <= S_RSTPC;
      opcode    <= '0;
      funct     <= '0;
    end else begin
      cur_state <= next_state;
      if (cur_state == S_IF) begin
        opcode <= instr[31:26];
        funct  <= instr[5:0];
      end
    end
  end

  always_comb begin
    next_state = S_RSTPC;
    case (cur_state)
      S_RSTPC: next_state = S_IF;
      S_IF:    next_state = S_ID;
      S_ID: begin
        case (instr_class)
          I_J, I_JAL, I_JR, I_NOP: next_state = S_IF;
          I_HALT:                  next_state = S_HALT;
          default:                 next_state = S_EXE;
        endcase
      end
      S_EXE: begin
        case (instr_class)
          I_LW, I_SW:       next_state = S_MEM;
          I_RTYPE, I_ADDI:  next_state = S_WB;
          default:          next_state = S_IF;
        endcase
      end
      S_MEM:   next_state = (instr_class == I_LW) ? S_WB : S_IF;
      S_WB:    next_state = S_IF;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RSTPC;
    endcase
  end

  // Each instruction releases the PC (non-hold PCSel) only in its final cycle.
  always_comb begin
    PCSel    = PC_HOLD;
    bne      = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Link     = 1'b0;
    ALUOp    = ALU_ADD;
    halted   = 1'b0;
    case (cur_state)
      S_RSTPC: PCSel = PC_RESET;
      S_IF:    IRWrite = 1'b1;
      S_ID: begin
        case (instr_class)
          I_J:   PCSel = PC_JMP;
          I_JAL: begin
            PCSel    = PC_JMP;
            RegWrite = 1'b1;
            Link     = 1'b1;
          end
          I_JR:    PCSel = PC_JR;
          I_NOP:   PCSel = PC_PLUS4;
          default: PCSel = PC_HOLD;
        endcase
      end
      S_EXE: begin
        case (instr_class)
          I_BEQ, I_BNE: begin
            PCSel = PC_BRANCH;
            ALUOp = ALU_SUB;
            bne   = (instr_class == I_BNE);
          end
          I_RTYPE: ALUOp = ALU_RTYPE;
          default: ALUOp = ALU_ADD;
        endcase
      end
      S_MEM: begin
        case (instr_class)
          I_SW: begin
            MemWrite = 1'b1;
            PCSel    = PC_PLUS4;
          end
          I_LW:    MemRead = 1'b1;
          default: PCSel = PC_HOLD;
        endcase
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemRead  = (instr_class == I_LW);
        PCSel    = PC_PLUS4;
      end
      S_HALT:  halted = 1'b1;
      default: PCSel = PC_HOLD;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: directed reset/lw/bne/jr/
// sw-reset/halt scenarios plus a random instruction stream against a cycle model.
module tb_multi_cycle_control_unit;
  import cpu_defs_pkg::*;

  logic        CLK;
  logic        Reset;
  logic [31:0] instr;
  logic [2:0]  PCSel;
  logic        bne;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Link;
  logic [2:0]  ALUOp;
  logic [2:0]  state;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] observed;

  multi_cycle_control_unit dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .instr    (instr),
    .PCSel    (PCSel),
    .bne      (bne),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Link     (Link),
    .ALUOp    (ALUOp),
    .state    (state),
    .halted   (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed view: {state, PCSel, ALUOp, IRWrite, RegWrite, MemRead, MemWrite, Link, bne, halted}
  assign observed = {state, PCSel, ALUOp, IRWrite, RegWrite, MemRead, MemWrite, Link, bne, halted};

  function automatic logic [15:0] mkExp(input state_t st, input logic [2:0] pc, input logic [2:0] alu,
                                        input logic irw, input logic rw, input logic mr, input logic mw,
                                        input logic lnk, input logic bn, input logic hlt);
    return {3'(st), pc, alu, irw, rw, mr, mw, lnk, bn, hlt};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    instr = w;
  endtask

  // Instruction-level model: latency from the instruction kind, PC released only in the last cycle.
  task automatic modelInstr(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic is_r, is_jr, is_j, is_jal, is_br, is_lw, is_sw, is_addi, is_nop, last;
    int n;
    state_t path[5];
    state_t st;
    logic [2:0] final_pc, pc, alu;
    op = w[31:26];
    fn = w[5:0];
    is_r    = (op == 6'd0);
    is_jr   = is_r && (fn == 6'd8);
    is_j    = (op == 6'd2);
    is_jal  = (op == 6'd3);
    is_br   = (op == 6'd4) || (op == 6'd5);
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2b);
    is_addi = (op == 6'd8);
    is_nop  = !(is_r || is_j || is_jal || is_br || is_lw || is_sw || is_addi || op == 6'h3f);
    if (is_j || is_jal || is_jr || is_nop) n = 2;
    else if (is_br) n = 3;
    else if (is_lw) n = 5;
    else n = 4;
    path[0] = S_IF;
    path[1] = S_ID;
    path[2] = S_EXE;
    path[3] = (is_lw || is_sw) ? S_MEM : S_WB;
    path[4] = S_WB;
    if (is_j || is_jal) final_pc = 3'b010;
    else if (is_jr) final_pc = 3'b011;
    else if (is_br) final_pc = 3'b001;
    else final_pc = 3'b000;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      st   = path[i];
      pc   = last ? final_pc : 3'b111;
      alu  = (st == S_EXE) ? (is_br ? 3'b001 : (is_r ? 3'b010 : 3'b000)) : 3'b000;
      exp_q.push_back(mkExp(st, pc, alu, i == 0, (last && is_jal) || st == S_WB,
                            is_lw && (st == S_MEM || st == S_WB), is_sw && last,
                            is_jal && last, is_br && last && op == 6'd5, 1'b0));
    end
  endtask

  // Runs one instruction from IF; entry and exit are both 1 time unit after an edge.
  task automatic runInstr(input logic [31:0] w, input string tag);
    modelInstr(w);
    applyStimulus(w);
    foreach (exp_q[i]) begin
      checkOutput($sformatf("%s_c%0d", tag, i), observed, exp_q[i]);
      checkOutput($sformatf("%s_memexcl", tag), {15'd0, MemRead & MemWrite}, 16'd0);
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] unknown_ops[5];
    logic [5:0] op;
    logic [31:0] w;
    unknown_ops = '{6'h01, 6'h06, 6'h0f, 6'h20, 6'h3e};
    case ($urandom_range(0, 8))
      0: op = 6'h00;
      1: op = 6'h02;
      2: op = 6'h03;
      3: op = 6'h04;
      4: op = 6'h05;
      5: op = 6'h08;
      6: op = 6'h23;
      7: op = 6'h2b;
      default: op = unknown_ops[$urandom_range(0, 4)];
    endcase
    w = $urandom;
    w[31:26] = op;
    if (op == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = 6'h08;
    return w;
  endfunction

  localparam logic [15:0] RST_VEC = {3'(S_RSTPC), 3'b100, 3'b000, 7'b0};

  initial begin
    Reset = 1'b1;
    instr = 32'd0;
    #1;
    checkOutput("reset_async", observed, RST_VEC);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_held", observed, RST_VEC);
    Reset = 1'b0;
    checkOutput("rstpc_after_release", observed, RST_VEC);
    @(posedge CLK);
    #1;
    checkOutput("if_after_rstpc", observed, mkExp(S_IF, 3'b111, 3'b000, 1, 0, 0, 0, 0, 0, 0));

    // Mid-cycle reset pulse from IF.
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("pulse_immediate", observed, RST_VEC);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    checkOutput("pulse_rstpc", observed, RST_VEC);
    @(posedge CLK);
    #1;
    checkOutput("pulse_if", observed, mkExp(S_IF, 3'b111, 3'b000, 1, 0, 0, 0, 0, 0, 0));

    runInstr(32'h8C020004, "lw");
    runInstr(32'h14220003, "bne");
    runInstr(32'h03E00008, "jr");
    runInstr(32'h10220003, "beq");
    runInstr(32'h0C000010, "jal");
    runInstr(32'hAC020004, "sw");

    for (int k = 0; k < 40; k++) begin
      runInstr(randInstr(), $sformatf("rand%0d", k));
    end

    // Reset asserted while sw is in MEM must drop MemWrite at once.
    applyStimulus(32'hAC030008);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("sw_mem", observed, mkExp(S_MEM, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0));
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("sw_reset_kill", observed, RST_VEC);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    checkOutput("sw_reset_rstpc", observed, RST_VEC);
    @(posedge CLK);
    #1;

    // Halt is absorbing until reset.
    applyStimulus(32'hFC000000);
    checkOutput("halt_if", observed, mkExp(S_IF, 3'b111, 3'b000, 1, 0, 0, 0, 0, 0, 0));
    @(posedge CLK);
    #1;
    checkOutput("halt_id", observed, mkExp(S_ID, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 100; k++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("halt_hold%0d", k), observed, mkExp(S_HALT, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 1));
    end
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("halt_reset", observed, RST_VEC);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("halt_reset_if", observed, mkExp(S_IF, 3'b111, 3'b000, 1, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
